// File: rtl/serial_link_pkg.sv
// Shared definitions for the correlator serial link (serializer and deserializer).
package serial_link_pkg;

  localparam int SER_WIDTH = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serial link: loads to zero, counts up and
// saturates at WIDTH-1. It exposes its next value so that registered outputs
// can be derived from the upcoming bit position.
module ser_bit_counter
  import serial_link_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             is_last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign is_last_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt_o     = cnt_q;
  assign cnt_d_o   = cnt_d;

  // Next count: a load wins, otherwise increment until the last bit position.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i && !is_last_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parallel_serializer.sv
// Parallel-to-serial transmitter: words arrive over valid/ready and leave MSB
// first, one bit per clock, with a frame strobe on each word's first bit. A
// one-word pending buffer lets consecutive words stream without a gap.
module parallel_serializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start
);

  localparam int CNT_W = $clog2(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_last;
  logic             cnt_load, cnt_inc;
  logic             accept;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;

  // Bit of a word at a given position counted from the MSB.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic [CNT_W-1:0] pos);
    logic [WIDTH-1:0] shifted;
    shifted = word << pos;
    return shifted[WIDTH-1];
  endfunction

  // The pending slot is the only thing that can refuse a word.
  assign in_ready = !pend_valid_q;
  assign accept   = in_valid && in_ready;

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;

  ser_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_i   (cnt_load),
    .inc_i    (cnt_inc),
    .cnt_o    (cnt_q),
    .cnt_d_o  (cnt_d),
    .is_last_o(is_last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath: on the last bit, pending word beats a fresh one.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d  = in_data;
          cnt_load = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (is_last) begin
          if (pend_valid_q) begin
            shreg_d      = pend_q;
            pend_valid_d = 1'b0;
            cnt_load     = 1'b1;
          end else if (accept) begin
            shreg_d  = in_data;
            cnt_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
          if (accept) begin
            pend_d       = in_data;
            pend_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs for the coming cycle, derived from next state so they leave flops.
  always_comb begin
    ser_valid_d   = (state_d == S_SHIFT);
    ser_out_d     = ser_valid_d && pick_bit(shreg_d, cnt_d);
    frame_start_d = ser_valid_d && (cnt_d == '0);
  end

  // Shift, pending and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q       <= '0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      shreg_q       <= shreg_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_parallel_serializer.sv
// Bench for parallel_serializer (WIDTH=3): a stream-level reference model
// schedules every accepted word's bits onto the output line, and a monitor
// compares the line cycle by cycle.
module tb_parallel_serializer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_start;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int cyc;
    bit b;
    bit fs;
  } exp_t;

  exp_t exp_q[$];
  int   starts_q[$];
  int   cyc       = 0;
  int   line_free = 0;

  parallel_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // The block can take a word only while no accepted word is still waiting
  // for the line to become free.
  function automatic bit model_ready(input int c);
    foreach (starts_q[i]) begin
      if (starts_q[i] > c) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: a word accepted at the end of cycle c occupies the line
  // from max(c+1, end of previous word) for W cycles, MSB first.
  initial begin
    int           st;
    logic [W-1:0] sh;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        starts_q.delete();
        line_free = 0;
      end else begin
        while (starts_q.size() > 0 && starts_q[0] <= cyc) void'(starts_q.pop_front());
        if (in_valid && model_ready(cyc)) begin
          st = (cyc + 1 > line_free) ? cyc + 1 : line_free;
          for (int i = 0; i < W; i++) begin
            sh = in_data << i;
            exp_q.push_back('{cyc: st + i, b: sh[W-1], fs: (i == 0)});
          end
          starts_q.push_back(st);
          line_free = st + W;
        end
      end
      if (clk) cyc++;
    end
  end

  // Monitor: every cycle the line must carry either the scheduled bit or idle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("ser_valid", ser_valid, 1);
        check("ser_out", ser_out, exp_q[0].b);
        check("frame_start", frame_start, exp_q[0].fs);
        void'(exp_q.pop_front());
      end else begin
        check("idle_ser_valid", ser_valid, 0);
        check("idle_ser_out", ser_out, 0);
        check("idle_frame_start", frame_start, 0);
      end
      check("in_ready", in_ready, model_ready(cyc));
    end
  end

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send(input logic [W-1:0] w);
    int tries = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    check("send_accepted", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    idle(2);

    // Single word
    send(3'b101);
    idle(5);

    // Back-to-back through the pending slot
    send(3'b110);
    send(3'b011);
    idle(6);

    // Direct load on the last-bit edge
    send(3'b111);
    idle(2);
    send(3'b100);
    idle(6);

    // Held valid with the pending slot full: incrementing pattern
    for (int i = 0; i < 10; i++) send(W'(i));
    idle(6);

    // Random words with random gaps
    repeat (40) begin
      send(W'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(6);

    // Reset during the second bit of a word while pend is full
    send(3'b111);
    send(3'b010);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_ser_valid", ser_valid, 0);
    check("async_rst_ser_out", ser_out, 0);
    check("async_rst_frame_start", frame_start, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send(3'b011);
    idle(8);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
    check("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parallel_serializer.md
# parallel_serializer

Parallel-to-serial transmitter that is the sending end of the correlator's serial input link. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB first, with a frame strobe on each word's first bit. A one-deep pending buffer lets back-to-back words stream with no idle gap, so the downstream deserializer sees a continuous bit stream.

## Interface
- WIDTH, 3, bits per word; legal range 2..32
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  parallel word to transmit
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block accepts a word this cycle; equals NOT pend_valid (combinational from state only)
- ser_out  output  1  serial data bit, registered
- ser_valid  output  1  ser_out carries a valid bit this cycle, registered
- frame_start  output  1  high only on the MSB (first bit) of each word, registered

## Operation
- Handshake: a word is accepted on a rising edge where in_valid && in_ready. in_data must be stable only in the cycle it is accepted.
- State:
  - shift register shreg[WIDTH-1:0]
  - bit counter cnt, range 0..WIDTH-1
  - pending register pend plus flag pend_valid
  - FSM with two states, IDLE and SHIFT
- IDLE:
  - ser_valid=0, ser_out=0, frame_start=0.
  - On an accept: load the word into shreg, set cnt=0, go to SHIFT.
  - pend stays empty.
- SHIFT:
  - ser_out=shreg[WIDTH-1-cnt], ser_valid=1, frame_start=(cnt==0).
  - On each edge with cnt<WIDTH-1: cnt increments.
  - On the edge where cnt==WIDTH-1 (last bit), pick the next word in this priority order:
    1. pend_valid: move pend into shreg, clear pend_valid, cnt=0, stay in SHIFT.
    2. Else if an accept happens on this edge: load the input word directly into shreg, cnt=0, stay in SHIFT.
    3. Else: go to IDLE.
  - An accept on any other SHIFT edge goes into pend and sets pend_valid.
- Simultaneous events: on the last-bit edge with pend_valid=1, in_ready is 0, so no second word can arrive that edge. pend never overflows.
- Counter wrap: cnt returns to 0 only via a load; it never counts past WIDTH-1.
- Reset, asserted at any time:
  - FSM goes to IDLE; shreg, pend, pend_valid and cnt clear to 0.
  - ser_out=0, ser_valid=0, frame_start=0, in_ready=1.
  - Any word in flight or pending is dropped. The first accept after deassertion starts a fresh frame.

## Timing
- Latency: a word accepted at edge k from IDLE drives its MSB during cycle k+1 (after edge k). Its LSB appears in cycle k+WIDTH.
- Throughput: one bit per clock. With pend kept full, the next word's MSB immediately follows the previous LSB, with zero gap cycles.
- in_ready is low from the edge that fills pend until the last-bit edge that drains it.
- All outputs except in_ready are flop outputs.

## Structure
- Shared package serial_link_pkg holds:
  - default WIDTH constant SER_WIDTH=3
  - FSM state enum ser_state_t {S_IDLE, S_SHIFT}
  - The future deserializer reuses both.
- Sub-module: ser_bit_counter (WIDTH-parameterised counter with load-to-zero and an is_last flag). Everything else stays flat in parallel_serializer.

## Test plan
Scenarios use WIDTH=3.
- Reset values: assert rst mid-stream, then release -> ser_valid=0, ser_out=0, frame_start=0 and in_ready=1 during reset and until the next accept.
- Single word: accept 3'b101 from IDLE -> ser_out 1,0,1 in the next three cycles, frame_start=1 only in the first; then ser_valid returns to 0.
- Back-to-back: accept 3'b110, then 3'b011 one cycle later -> ser_out 1,1,0,0,1,1 contiguous with ser_valid held high; frame_start on bits 1 and 4; in_ready low for two cycles.
- Direct load on last bit: with pend empty, accept 3'b100 exactly on the last-bit edge of a prior word -> its MSB follows with no gap, and pend_valid stays 0.
- Backpressure: hold in_valid high with pend full -> no word is lost or duplicated over 10 consecutive words (incrementing pattern), checked by a scoreboard.
- Reset mid-operation: assert rst during the second bit of a word with pend full -> outputs go to 0 asynchronously, and after release the next word 3'b011 serialises as 0,1,1 with frame_start on its first bit.
